// File: rtl/dual_issue_fetch_queue.sv
// -----------------------------------------------------------------------------
// dual_issue_fetch_queue
//
// Instruction queue between fetch and the hazard detection stage. Fetch pushes
// up to two instructions per cycle. Each accepted instruction is tagged with a
// unique non-zero ID. The two oldest entries are presented combinationally as
// the issue pair. The hazard stage retires 0..2 head entries per cycle.
//
// Ports
//   clk                      clock, rising edge
//   reset                    asynchronous, active-low reset
//   flush                    branch redirect, empties the queue (next_id kept)
//   push0_valid/push1_valid  fetch slot valids (slot 1 is younger)
//   push_instruction0/1      fetched instructions
//   push_pc0/1               fetched PCs
//   push_ready               at least two free entries this cycle
//   pop_count                head entries consumed this cycle (3 acts as 2)
//   instruction0/1_out       head / head+1 instruction, 0 when absent
//   pc0/1_out, id0/1_out     head / head+1 pc and id, 0 when absent
//   valid0/1_out             head / head+1 entry present
//   count                    occupied entries
//   empty_cycles             (FETCH_QUEUE_PERF_EN only) saturating empty counter
//   stall_cycles             (FETCH_QUEUE_PERF_EN only) saturating stall counter
//
// Build option: define FETCH_QUEUE_PERF_EN to add the performance counters.
// -----------------------------------------------------------------------------
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_ID_WIDTH
`define INSTRUCTION_ID_WIDTH 8
`endif

module dual_issue_fetch_queue #(
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              push0_valid,
    input  logic                              push1_valid,
    input  logic [`INST_WIDTH-1:0]            push_instruction0,
    input  logic [`INST_WIDTH-1:0]            push_instruction1,
    input  logic [`ADDR_WIDTH-1:0]            push_pc0,
    input  logic [`ADDR_WIDTH-1:0]            push_pc1,
    output logic                              push_ready,
    input  logic [1:0]                        pop_count,
    output logic [`INST_WIDTH-1:0]            instruction0_out,
    output logic [`INST_WIDTH-1:0]            instruction1_out,
    output logic [`ADDR_WIDTH-1:0]            pc0_out,
    output logic [`ADDR_WIDTH-1:0]            pc1_out,
    output logic [`INSTRUCTION_ID_WIDTH-1:0]  id0_out,
    output logic [`INSTRUCTION_ID_WIDTH-1:0]  id1_out,
    output logic                              valid0_out,
    output logic                              valid1_out,
    output logic [DEPTH_LOG2:0]               count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                       empty_cycles,
    output logic [31:0]                       stall_cycles
`endif
);

    localparam int IW  = `INST_WIDTH;
    localparam int AW  = `ADDR_WIDTH;
    localparam int IDW = `INSTRUCTION_ID_WIDTH;
    localparam int CW  = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    // Entry storage is deliberately not reset.
    logic [IW-1:0]  inst_mem [DEPTH];
    logic [AW-1:0]  pc_mem   [DEPTH];
    logic [IDW-1:0] id_mem   [DEPTH];

    logic [CW-1:0]  count_q, count_d;
    ptr_t           rd_ptr_q, rd_ptr_d;
    ptr_t           wr_ptr_q, wr_ptr_d;
    ptr_t           rd_ptr_p1;
    logic [IDW-1:0] next_id_q, next_id_d;

    logic [1:0]     pop_eff;
    logic [CW-1:0]  pops;
    logic [CW-1:0]  n_push;
    logic           push_acc;
    logic           we0, we1;
    logic [IW-1:0]  w0_inst;
    logic [AW-1:0]  w0_pc;
    logic [IDW-1:0] id_a, id_b;

    // IDs wrap past the maximum straight to 1; 0 is reserved for bubbles.
    function automatic logic [IDW-1:0] id_inc(input logic [IDW-1:0] x);
        return (x == '1) ? IDW'(1) : x + IDW'(1);
    endfunction

    always_comb begin
        push_ready = (count_q <= CW'(DEPTH - 2));
        push_acc   = push_ready && !flush;

        pop_eff = (pop_count == 2'd3) ? 2'd2 : pop_count;
        pops    = (CW'(pop_eff) > count_q) ? count_q : CW'(pop_eff);

        n_push = CW'(push_acc && push0_valid) + CW'(push_acc && push1_valid);

        id_a = next_id_q;
        id_b = id_inc(next_id_q);

        // Compaction: the first valid slot always lands at wr_ptr.
        we0     = push_acc && (push0_valid || push1_valid);
        we1     = push_acc && push0_valid && push1_valid;
        w0_inst = push0_valid ? push_instruction0 : push_instruction1;
        w0_pc   = push0_valid ? push_pc0 : push_pc1;

        case (n_push)
            CW'(1):  next_id_d = id_b;
            CW'(2):  next_id_d = id_inc(id_b);
            default: next_id_d = next_id_q;
        endcase

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q - pops + n_push;
            rd_ptr_d = rd_ptr_q + ptr_t'(pops);
            wr_ptr_d = wr_ptr_q + ptr_t'(n_push);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            next_id_q <= IDW'(1);
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            next_id_q <= next_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) begin
            inst_mem[wr_ptr_q] <= w0_inst;
            pc_mem[wr_ptr_q]   <= w0_pc;
            id_mem[wr_ptr_q]   <= id_a;
        end
        if (we1) begin
            inst_mem[wr_ptr_q + ptr_t'(1)] <= push_instruction1;
            pc_mem[wr_ptr_q + ptr_t'(1)]   <= push_pc1;
            id_mem[wr_ptr_q + ptr_t'(1)]   <= id_b;
        end
    end

    // Slot 1 index wraps naturally through the pointer width.
    assign rd_ptr_p1 = rd_ptr_q + ptr_t'(1);

    always_comb begin
        valid0_out       = (count_q != '0);
        valid1_out       = (count_q >= CW'(2));
        instruction0_out = valid0_out ? inst_mem[rd_ptr_q]  : '0;
        pc0_out          = valid0_out ? pc_mem[rd_ptr_q]    : '0;
        id0_out          = valid0_out ? id_mem[rd_ptr_q]    : '0;
        instruction1_out = valid1_out ? inst_mem[rd_ptr_p1] : '0;
        pc1_out          = valid1_out ? pc_mem[rd_ptr_p1]   : '0;
        id1_out          = valid1_out ? id_mem[rd_ptr_p1]   : '0;
        count            = count_q;
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] empty_cycles_q, stall_cycles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty_cycles_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            if ((count_q == '0) && !flush && (empty_cycles_q != '1))
                empty_cycles_q <= empty_cycles_q + 32'd1;
            if (valid0_out && (pop_count == 2'd0) && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign empty_cycles = empty_cycles_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_fetch_queue
//
// Self-checking bench: directed scenarios followed by random traffic, each
// cycle compared against a queue-based reference model.
// -----------------------------------------------------------------------------
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_ID_WIDTH
`define INSTRUCTION_ID_WIDTH 8
`endif

module tb_dual_issue_fetch_queue;

    localparam int DEPTH      = 8;
    localparam int DEPTH_LOG2 = 3;
    localparam int IW    = `INST_WIDTH;
    localparam int AW    = `ADDR_WIDTH;
    localparam int IDW   = `INSTRUCTION_ID_WIDTH;
    localparam int IDMAX = (1 << IDW) - 1;

    logic                clk;
    logic                reset;
    logic                flush;
    logic                push0_valid, push1_valid;
    logic [IW-1:0]       push_instruction0, push_instruction1;
    logic [AW-1:0]       push_pc0, push_pc1;
    logic                push_ready;
    logic [1:0]          pop_count;
    logic [IW-1:0]       instruction0_out, instruction1_out;
    logic [AW-1:0]       pc0_out, pc1_out;
    logic [IDW-1:0]      id0_out, id1_out;
    logic                valid0_out, valid1_out;
    logic [DEPTH_LOG2:0] count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]         empty_cycles, stall_cycles;
    longint              exp_empty, exp_stall;
`endif

    dual_issue_fetch_queue #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .push0_valid       (push0_valid),
        .push1_valid       (push1_valid),
        .push_instruction0 (push_instruction0),
        .push_instruction1 (push_instruction1),
        .push_pc0          (push_pc0),
        .push_pc1          (push_pc1),
        .push_ready        (push_ready),
        .pop_count         (pop_count),
        .instruction0_out  (instruction0_out),
        .instruction1_out  (instruction1_out),
        .pc0_out           (pc0_out),
        .pc1_out           (pc1_out),
        .id0_out           (id0_out),
        .id1_out           (id1_out),
        .valid0_out        (valid0_out),
        .valid1_out        (valid1_out),
        .count             (count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .empty_cycles      (empty_cycles),
        .stall_cycles      (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc;
        int            id;
    } ent_t;

    ent_t mq[$];
    int   nid;
    int   tests_run;
    int   tests_failed;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_of(input int x);
        return (x >= IDMAX) ? 1 : x + 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        nid = 1;
`ifdef FETCH_QUEUE_PERF_EN
        exp_empty = 0;
        exp_stall = 0;
`endif
    endtask

    // Reference behaviour for one clock edge, computed from the pre-edge state.
    task automatic model_cycle(input logic f, input logic v0, input logic v1, input logic [1:0] pcnt,
                               input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                               input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        int  npop;
        bit  ready;
        ent_t e;
`ifdef FETCH_QUEUE_PERF_EN
        if (mq.size() == 0 && !f && exp_empty < 64'hFFFFFFFF) exp_empty++;
        if (mq.size() > 0 && pcnt == 0 && exp_stall < 64'hFFFFFFFF) exp_stall++;
`endif
        if (f) begin
            mq.delete();
            return;
        end
        ready = (DEPTH - mq.size()) >= 2;
        npop  = (pcnt == 3) ? 2 : int'(pcnt);
        if (npop > mq.size()) npop = mq.size();
        repeat (npop) void'(mq.pop_front());
        if (ready && v0) begin
            e.inst = i0; e.pc = p0; e.id = nid;
            mq.push_back(e);
            nid = next_of(nid);
        end
        if (ready && v1) begin
            e.inst = i1; e.pc = p1; e.id = nid;
            mq.push_back(e);
            nid = next_of(nid);
        end
    endtask

    task automatic compare_all(input string tag);
        ent_t z, s0, s1;
        z.inst = '0; z.pc = '0; z.id = 0;
        s0 = (mq.size() > 0) ? mq[0] : z;
        s1 = (mq.size() > 1) ? mq[1] : z;
        check_eq({tag, ".count"}, 64'(count), 64'(mq.size()));
        check_eq({tag, ".push_ready"}, 64'(push_ready), 64'((DEPTH - mq.size()) >= 2));
        check_eq({tag, ".valid0"}, 64'(valid0_out), 64'(mq.size() > 0));
        check_eq({tag, ".valid1"}, 64'(valid1_out), 64'(mq.size() > 1));
        check_eq({tag, ".inst0"}, 64'(instruction0_out), 64'(s0.inst));
        check_eq({tag, ".inst1"}, 64'(instruction1_out), 64'(s1.inst));
        check_eq({tag, ".pc0"}, 64'(pc0_out), 64'(s0.pc));
        check_eq({tag, ".pc1"}, 64'(pc1_out), 64'(s1.pc));
        check_eq({tag, ".id0"}, 64'(id0_out), 64'(s0.id));
        check_eq({tag, ".id1"}, 64'(id1_out), 64'(s1.id));
`ifdef FETCH_QUEUE_PERF_EN
        check_eq({tag, ".empty_cycles"}, 64'(empty_cycles), 64'(exp_empty));
        check_eq({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(exp_stall));
`endif
    endtask

    // Drive one cycle with random instruction words, clock it, then compare.
    task automatic step(input string tag, input logic f, input logic v0, input logic v1,
                        input logic [1:0] pcnt, input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        flush             = f;
        push0_valid       = v0;
        push1_valid       = v1;
        pop_count         = pcnt;
        push_instruction0 = IW'($urandom);
        push_instruction1 = IW'($urandom);
        push_pc0          = p0;
        push_pc1          = p1;
        model_cycle(f, v0, v1, pcnt, push_instruction0, push_instruction1, p0, p1);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        model_reset();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        int guard;
        int last_id;
        tests_run    = 0;
        tests_failed = 0;
        flush = 0; push0_valid = 0; push1_valid = 0; pop_count = 0;
        push_instruction0 = '0; push_instruction1 = '0; push_pc0 = '0; push_pc1 = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        check_eq("reset.push_ready_const", 64'(push_ready), 64'd1);
        reset = 1'b1;
        #2;

        // Scenario 1: first pair gets ids 1 and 2.
        step("t1", 0, 1, 1, 2'd0, 32'h0, 32'h4);
        check_eq("t1.id0_abs", 64'(id0_out), 64'd1);
        check_eq("t1.id1_abs", 64'(id1_out), 64'd2);
        check_eq("t1.pc1_abs", 64'(pc1_out), 64'd4);

        // Scenario 2: fill to DEPTH-2, then a push is dropped.
        step("t2.fill", 0, 1, 1, 2'd0, 32'h8, 32'hC);
        step("t2.fill", 0, 1, 1, 2'd0, 32'h10, 32'h14);
        check_eq("t2.full_ready", 64'(push_ready), 64'd1);
        step("t2.fill", 0, 1, 1, 2'd0, 32'h18, 32'h1C);
        // count is now 8; wait, the spec example stops at 6, so pop back down.
        step("t2.pop", 0, 0, 0, 2'd2, 32'h0, 32'h0);
        check_eq("t2.count6", 64'(count), 64'd6);
        check_eq("t2.ready_at6", 64'(push_ready), 64'd1);
        step("t2.to8", 0, 1, 1, 2'd0, 32'h20, 32'h24);
        check_eq("t2.ready_at8", 64'(push_ready), 64'd0);
        step("t2.drop", 0, 1, 1, 2'd0, 32'h28, 32'h2C);
        check_eq("t2.drop_count", 64'(count), 64'd8);

        // Scenario 3: count=3, pop 1 plus push pair -> 4.
        do_reset();
        step("t3.a", 0, 1, 1, 2'd0, 32'h100, 32'h104);
        step("t3.b", 0, 1, 0, 2'd0, 32'h108, 32'h0);
        step("t3.c", 0, 1, 1, 2'd1, 32'h10C, 32'h110);
        check_eq("t3.count4", 64'(count), 64'd4);
        check_eq("t3.pc0_old1", 64'(pc0_out), 64'h104);

        // Scenario 4: count=1, pop 2 -> empty, outputs zero.
        step("t4.a", 0, 0, 0, 2'd3, 32'h0, 32'h0);
        step("t4.b", 0, 0, 0, 2'd1, 32'h0, 32'h0);
        step("t4.c", 0, 0, 0, 2'd2, 32'h0, 32'h0);
        check_eq("t4.count0", 64'(count), 64'd0);
        check_eq("t4.valid0", 64'(valid0_out), 64'd0);

        // Scenario 5: flush with count=5 while pushing; ids are not reused.
        step("t5.a", 0, 1, 1, 2'd0, 32'h200, 32'h204);
        step("t5.b", 0, 1, 1, 2'd0, 32'h208, 32'h20C);
        step("t5.c", 0, 0, 1, 2'd0, 32'h0, 32'h210);
        check_eq("t5.count5", 64'(count), 64'd5);
        last_id = nid;
        step("t5.flush", 1, 1, 1, 2'd1, 32'h214, 32'h218);
        check_eq("t5.flush_count", 64'(count), 64'd0);
        step("t5.after", 0, 1, 0, 2'd0, 32'h21C, 32'h0);
        check_eq("t5.next_id", 64'(id0_out), 64'(last_id));

        // Async reset mid-operation, then the first id is 1 again.
        step("rst.pre", 0, 1, 1, 2'd0, 32'h300, 32'h304);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("rst.async");
        #2;
        reset = 1'b1;
        step("rst.first", 0, 1, 0, 2'd0, 32'h308, 32'h0);
        check_eq("rst.first_id", 64'(id0_out), 64'd1);

        // Scenario 6: walk next_id up to max-1, then push three across the wrap.
        guard = 0;
        while (nid != IDMAX - 1 && guard < 1000) begin
            if (nid + 2 <= IDMAX - 1)
                step("t6.walk", 0, 1, 1, 2'd2, 32'h400, 32'h404);
            else
                step("t6.walk", 0, 1, 0, 2'd2, 32'h400, 32'h0);
            guard++;
        end
        check_eq("t6.walk_bound", 64'(guard < 1000), 64'd1);
        step("t6.flush", 1, 0, 0, 2'd0, 32'h0, 32'h0);
        step("t6.pair", 0, 1, 1, 2'd0, 32'h500, 32'h504);
        step("t6.single", 0, 1, 0, 2'd1, 32'h508, 32'h0);
        check_eq("t6.id_max", 64'(id0_out), 64'(IDMAX));
        check_eq("t6.id_wrap", 64'(id1_out), 64'd1);

        // Random traffic; pointer wrap (rd_ptr=DEPTH-1) is exercised repeatedly.
        for (int i = 0; i < 3000; i++) begin
            step("rand", ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                 2'($urandom), AW'($urandom), AW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
